// File: rtl/aes_round_ctrl.sv
// AES round sequencer: steps one 128-bit block through the initial AddRoundKey
// and NUM_ROUNDS rounds of SubBytes/ShiftRows/MixColumns/AddRoundKey, byte-serially.
// Optional build macro: AES_KEYSTALL_EN. When it is defined, the AddRoundKey
// phases wait on key_valid. around_enable is then gated combinationally by
// key_valid, so a byte is only applied in a cycle where its subkey is present.
module aes_round_ctrl #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic       key_valid,
  output logic       busy,
  output logic       done,
  output logic       around_enable,
  output logic       sub_enable,
  output logic       shift_enable,
  output logic       mix_enable,
  output logic       key_req,
  output logic [3:0] byte_idx,
  output logic [1:0] col_idx,
  output logic [3:0] round_num
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
  localparam logic [3:0] LAST_BYTE  = 4'd15;
  localparam logic [1:0] LAST_COL   = 2'd3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INIT_ARK = 3'd1,
    SUB      = 3'd2,
    SHIFT    = 3'd3,
    MIX      = 3'd4,
    ARK      = 3'd5,
    DONE     = 3'd6
  } state_t;

  state_t state;
  logic   around_q;
  logic   ark_go;

`ifdef AES_KEYSTALL_EN
  // AddRoundKey advances only when the subkey byte is present
  assign ark_go        = key_valid;
  assign around_enable = around_q & key_valid;
`else
  // Key delivery is assumed to keep pace; key_valid is not observed
  logic unused_key_valid;
  assign unused_key_valid = key_valid;
  assign ark_go           = 1'b1;
  assign around_enable    = around_q;
`endif

  // Sequencer state, counters and registered phase enables
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      around_q     <= 1'b0;
      sub_enable   <= 1'b0;
      shift_enable <= 1'b0;
      mix_enable   <= 1'b0;
      key_req      <= 1'b0;
      byte_idx     <= 4'd0;
      col_idx      <= 2'd0;
      round_num    <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= INIT_ARK;
            busy      <= 1'b1;
            around_q  <= 1'b1;
            key_req   <= 1'b1;
            byte_idx  <= 4'd0;
            col_idx   <= 2'd0;
            round_num <= 4'd0;
          end
        end
        INIT_ARK: begin
          if (ark_go) begin
            if (byte_idx == LAST_BYTE) begin
              state      <= SUB;
              round_num  <= 4'd1;
              byte_idx   <= 4'd0;
              around_q   <= 1'b0;
              key_req    <= 1'b0;
              sub_enable <= 1'b1;
            end else begin
              byte_idx <= byte_idx + 4'd1;
            end
          end
        end
        SUB: begin
          if (byte_idx == LAST_BYTE) begin
            state        <= SHIFT;
            byte_idx     <= 4'd0;
            sub_enable   <= 1'b0;
            shift_enable <= 1'b1;
          end else begin
            byte_idx <= byte_idx + 4'd1;
          end
        end
        SHIFT: begin
          shift_enable <= 1'b0;
          if (round_num < LAST_ROUND) begin
            state      <= MIX;
            col_idx    <= 2'd0;
            mix_enable <= 1'b1;
          end else begin
            // Final round has no MixColumns
            state    <= ARK;
            byte_idx <= 4'd0;
            around_q <= 1'b1;
            key_req  <= 1'b1;
          end
        end
        MIX: begin
          if (col_idx == LAST_COL) begin
            state      <= ARK;
            col_idx    <= 2'd0;
            byte_idx   <= 4'd0;
            mix_enable <= 1'b0;
            around_q   <= 1'b1;
            key_req    <= 1'b1;
          end else begin
            col_idx <= col_idx + 2'd1;
          end
        end
        ARK: begin
          if (ark_go) begin
            if (byte_idx == LAST_BYTE) begin
              byte_idx <= 4'd0;
              around_q <= 1'b0;
              key_req  <= 1'b0;
              if (round_num == LAST_ROUND) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state      <= SUB;
                round_num  <= round_num + 4'd1;
                sub_enable <= 1'b1;
              end
            end else begin
              byte_idx <= byte_idx + 4'd1;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          round_num <= 4'd0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: a per-cycle expected trace is built
// from the round schedule (phase lengths, key_valid pattern) and compared to
// both a 10-round and a 14-round instance.
module tb_aes_round_ctrl;

`ifdef AES_KEYSTALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  logic clk = 1'b0;
  logic n_rst, start_a, start_b, key_valid;

  logic       busy_a, done_a, ae_a, se_a, sh_a, me_a, kr_a;
  logic [3:0] byte_a, round_a;
  logic [1:0] col_a;
  logic       busy_b, done_b, ae_b, se_b, sh_b, me_b, kr_b;
  logic [3:0] byte_b, round_b;
  logic [1:0] col_b;

  aes_round_ctrl #(.NUM_ROUNDS(10)) dut_a (
    .clk(clk), .n_rst(n_rst), .start(start_a), .key_valid(key_valid),
    .busy(busy_a), .done(done_a), .around_enable(ae_a), .sub_enable(se_a),
    .shift_enable(sh_a), .mix_enable(me_a), .key_req(kr_a),
    .byte_idx(byte_a), .col_idx(col_a), .round_num(round_a));

  aes_round_ctrl #(.NUM_ROUNDS(14)) dut_b (
    .clk(clk), .n_rst(n_rst), .start(start_b), .key_valid(key_valid),
    .busy(busy_b), .done(done_b), .around_enable(ae_b), .sub_enable(se_b),
    .shift_enable(sh_b), .mix_enable(me_b), .key_req(kr_b),
    .byte_idx(byte_b), .col_idx(col_b), .round_num(round_b));

  always #5 clk = ~clk;

  // {busy, done, around, sub, shift, mix, key_req, byte[4], col[2], round[4]}
  logic [16:0] obs_a, obs_b;
  assign obs_a = {busy_a, done_a, ae_a, se_a, sh_a, me_a, kr_a, byte_a, col_a, round_a};
  assign obs_b = {busy_b, done_b, ae_b, se_b, sh_b, me_b, kr_b, byte_b, col_b, round_b};

  int checks = 0;
  int fails  = 0;
  logic [16:0] exp_q[$];
  int done_cyc;
  bit kv[1:800];

  function automatic logic [16:0] rec(bit ae, bit se, bit sh, bit me, bit kr,
                                      int b, int c, int r);
    return {1'b1, 1'b0, ae, se, sh, me, kr, 4'(b), 2'(c), 4'(r)};
  endfunction

  task automatic check(input string tag, input int cyc,
                       input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, got, want);
    end
  endtask

  // One AddRoundKey byte, preceded by stall cycles while its key is absent
  task automatic ark_byte(input int r, input int b);
    if (STALL)
      while (!kv[exp_q.size() + 1] && exp_q.size() < 790)
        exp_q.push_back(rec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, b, 0, r));
    exp_q.push_back(rec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, b, 0, r));
  endtask

  // Expected trace: entry k-1 is cycle k after the accepting edge
  task automatic build(input int nr);
    exp_q.delete();
    for (int b = 0; b < 16; b++) ark_byte(0, b);
    for (int r = 1; r <= nr; r++) begin
      for (int b = 0; b < 16; b++) exp_q.push_back(rec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, b, 0, r));
      exp_q.push_back(rec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, r));
      if (r < nr)
        for (int c = 0; c < 4; c++) exp_q.push_back(rec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, c, r));
      for (int b = 0; b < 16; b++) ark_byte(r, b);
    end
    exp_q.push_back({1'b1, 1'b1, 5'b0, 4'd0, 2'd0, 4'(nr)});
    done_cyc = exp_q.size();
    exp_q.push_back(17'd0);
  endtask

  task automatic run(input string tag, input int s, input int nr, input int abort_at,
                     input bit hold, input int exp_done);
    int done_seen = 0;
    int n_sub = 0, n_sh = 0, n_mix = 0, n_ae = 0, n_multi = 0;
    logic [16:0] o;
    build(nr);
    if (s == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk); #1;
    if (!hold) begin start_a = 1'b0; start_b = 1'b0; end
    for (int i = 0; i < exp_q.size(); i++) begin
      key_valid = kv[i + 1];
      @(negedge clk);
      o = (s == 0) ? obs_a : obs_b;
      check(tag, i + 1, 32'(o), 32'(exp_q[i]));
      if (o[15] && done_seen == 0) done_seen = i + 1;
      n_ae  += int'(o[14]);
      n_sub += int'(o[13]);
      n_sh  += int'(o[12]);
      n_mix += int'(o[11]);
      if ($countones(o[14:11]) > 1) n_multi++;
      if (i + 1 == abort_at) begin
        n_rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_rst_outputs"}, i + 2, 32'((s == 0) ? obs_a : obs_b), 32'd0);
        check({tag, "_no_done"}, i + 2, 32'(done_seen), 32'd0);
        return;
      end
      @(posedge clk); #1;
    end
    check({tag, "_done_cycle"}, done_seen, 32'(done_seen), 32'((exp_done != 0) ? exp_done : done_cyc));
    check({tag, "_sub_count"}, 0, 32'(n_sub), 32'(16 * nr));
    check({tag, "_shift_count"}, 0, 32'(n_sh), 32'(nr));
    check({tag, "_mix_count"}, 0, 32'(n_mix), 32'(4 * (nr - 1)));
    check({tag, "_ark_count"}, 0, 32'(n_ae), 32'(16 * (nr + 1)));
    check({tag, "_onehot"}, 0, 32'(n_multi), 32'd0);
    if (hold) begin
      @(negedge clk);
      check({tag, "_restart"}, 1, 32'((s == 0) ? obs_a : obs_b),
            32'(rec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0)));
    end
  endtask

  initial begin
    n_rst = 1'b0; start_a = 1'b0; start_b = 1'b0; key_valid = 1'b1;
    for (int i = 1; i <= 800; i++) kv[i] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_a", 0, 32'(obs_a), 32'd0);
    check("reset_b", 0, 32'(obs_b), 32'd0);

    // First edge with n_rst high also accepts start
    @(posedge clk); #1;
    n_rst = 1'b1;
    run("plain10", 0, 10, 0, 1'b0, 383);
    run("plain14", 1, 14, 0, 1'b0, 531);

    // key_valid low for 3 cycles at round 2, byte 7 (cycles 82-84)
    for (int i = 82; i <= 84; i++) kv[i] = 1'b0;
    run("kvstall", 0, 10, 0, 1'b0, STALL ? 386 : 383);
    for (int i = 1; i <= 800; i++) kv[i] = ($urandom_range(0, 3) != 0);
    run("random_kv", 0, 10, 0, 1'b0, 0);
    for (int i = 1; i <= 800; i++) kv[i] = 1'b1;

    // start held high through DONE: one IDLE cycle with busy low, then restart
    run("hold_start", 0, 10, 0, 1'b1, 383);
    @(posedge clk); #1;
    n_rst = 1'b0; start_a = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(negedge clk);
    check("idle_after_hold", 0, 32'(obs_a), 32'd0);
    @(posedge clk); #1;

    // Reset asserted during round 5 MixColumns (cycle 183)
    run("abort", 0, 10, 183, 1'b0, 0);
    start_a = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("start_in_reset", 0, 32'(obs_a), 32'd0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    run("after_reset", 0, 10, 0, 1'b0, 383);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 10, meaning the number of cipher rounds after the initial AddRoundKey (legal values 10, 12, 14).
REQ-002 SHALL have ports: clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have ports: n_rst  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have ports: start  input  1  request to begin one block encryption.
REQ-005 SHALL have ports: key_valid  input  1  subkey byte for the current (round_num, byte_idx) is present.
REQ-006 SHALL have ports: busy  output  1  high from the cycle after start is accepted through the DONE cycle.
REQ-007 SHALL have ports: done  output  1  single-cycle pulse; the block is complete.
REQ-008 SHALL have ports: around_enable  output  1  drives the byte-serial AddRoundKey stage.
REQ-009 SHALL have ports: sub_enable, shift_enable, mix_enable  output  1 each  enables for SubBytes, ShiftRows and MixColumns.
REQ-010 SHALL have ports: key_req  output  1  subkey byte request, high in every ARK-phase cycle.
REQ-011 SHALL have ports: byte_idx  output  4  state byte currently addressed (0-15).
REQ-012 SHALL have ports: col_idx  output  2  column addressed during MixColumns.
REQ-013 SHALL have ports: round_num  output  4  current round (0 = initial AddRoundKey).

Function
REQ-014 SHALL implement FSM states IDLE, INIT_ARK, SUB, SHIFT, MIX, ARK, DONE.
REQ-015 SHALL in IDLE accept start=1 and move to INIT_ARK with round_num=0 and byte_idx=0; start in any other state SHALL be ignored.
REQ-016 SHALL in INIT_ARK and ARK assert around_enable and key_req, and increment byte_idx 0->15 one byte per cycle.
REQ-017 SHALL at byte_idx=15 leave INIT_ARK for SUB with round_num=1.
REQ-018 SHALL in SUB assert sub_enable for 16 cycles (byte_idx 0-15), then go to SHIFT.
REQ-019 SHALL in SHIFT assert shift_enable for exactly 1 cycle.
REQ-020 SHALL leave SHIFT for MIX when round_num<NUM_ROUNDS, otherwise for ARK (final round skips MixColumns).
REQ-021 SHALL in MIX assert mix_enable for 4 cycles with col_idx 0->3, then go to ARK.
REQ-022 SHALL at byte_idx=15 leave ARK for DONE when round_num=NUM_ROUNDS; otherwise go to SUB with round_num incremented.
REQ-023 SHALL in DONE assert done for one cycle, then return to IDLE.
REQ-024 SHALL assert at most one of around_enable, sub_enable, shift_enable, mix_enable in any cycle.
REQ-025 SHALL wrap byte_idx 15->0 and col_idx 3->0 on every phase change; both SHALL read 0 outside their active phases.
REQ-026 SHALL take 383 cycles for NUM_ROUNDS=10 with no stalls: INIT_ARK in cycles 1-16 after acceptance, rounds in 17-382, DONE in 383.

Reset
REQ-027 SHALL, when n_rst=0 at a clock edge, force state IDLE and all outputs to 0, including mid-operation, with no done pulse.
REQ-028 SHALL accept start on the first edge at which n_rst=1.

Configuration
REQ-029 SHALL, with AES_KEYSTALL_EN defined, deassert around_enable and hold byte_idx in INIT_ARK/ARK while key_valid=0, keeping key_req high; progress resumes on the edge where key_valid=1.
REQ-030 SHALL, without AES_KEYSTALL_EN, ignore key_valid and never stall; latency is always per REQ-026.

Verification
REQ-031 SHALL cover: reset release, start pulse, key_valid=1 -> done in cycle 383; sub_enable high for 160 cycles, shift_enable 10, mix_enable 36, around_enable 176.
REQ-032 SHALL cover: NUM_ROUNDS=14 -> final round has no mix_enable; done in cycle 16+13*37+33+1=531.
REQ-033 SHALL cover: start held high through DONE -> second run begins only after return to IDLE; busy stays 0 in that IDLE cycle.
REQ-034 SHALL cover: n_rst=0 during round 5 MIX -> next cycle all outputs 0 and state IDLE; done is never pulsed.
REQ-035 SHALL cover: AES_KEYSTALL_EN defined, key_valid=0 for 3 cycles at round 2 byte_idx=7 -> byte_idx holds 7 with around_enable=0 and key_req=1; done is delayed to cycle 386.
REQ-036 SHALL cover: AES_KEYSTALL_EN undefined with the same key_valid stimulus -> done in cycle 383.
